// File: rtl/fan_result_collector_pkg.sv
// Shared SIGMA defaults and the frame record used by the FAN result collector.
package fan_result_collector_pkg;

    localparam int unsigned NUM_PES_DEF       = 16;
    localparam int unsigned LOG2_PES_DEF      = 4;
    localparam int unsigned OUT_DATA_TYPE_DEF = 32;
    localparam int unsigned FIFO_DEPTH_DEF    = 4;
    localparam int unsigned LOG2_DEPTH_DEF    = 2;

    typedef struct packed {
        logic [NUM_PES_DEF-1:0]                   mask;
        logic [NUM_PES_DEF*OUT_DATA_TYPE_DEF-1:0] data;
    } frame_t;

endpackage

// File: rtl/fan_result_collector_if.sv
// Frame input and serial result output of the FAN result collector.
interface fan_result_collector_if #(
    parameter int unsigned NUM_PES       = fan_result_collector_pkg::NUM_PES_DEF,
    parameter int unsigned LOG2_PES      = fan_result_collector_pkg::LOG2_PES_DEF,
    parameter int unsigned OUT_DATA_TYPE = fan_result_collector_pkg::OUT_DATA_TYPE_DEF,
    parameter int unsigned LOG2_DEPTH    = fan_result_collector_pkg::LOG2_DEPTH_DEF
) ();

    logic [NUM_PES-1:0]               i_data_valid;
    logic [NUM_PES*OUT_DATA_TYPE-1:0] i_data_bus;
    logic                             i_ready;
    logic                             o_valid;
    logic [OUT_DATA_TYPE-1:0]         o_data;
    logic [LOG2_PES-1:0]              o_lane;
    logic                             o_last;
    logic                             o_overflow;
    logic [LOG2_DEPTH:0]              o_count;

    modport master (
        output i_data_valid, i_data_bus, i_ready,
        input  o_valid, o_data, o_lane, o_last, o_overflow, o_count
    );

    modport slave (
        input  i_data_valid, i_data_bus, i_ready,
        output o_valid, o_data, o_lane, o_last, o_overflow, o_count
    );

endinterface

// File: rtl/sigma_lsb_encoder.sv
// Lowest-set-bit encoder: index, one-hot and any-set flag of a mask.
module sigma_lsb_encoder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic [WIDTH-1:0] mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic             any_o
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = IDX_W'(i);
        end
    end

    assign onehot_o = mask_i & (~mask_i + WIDTH'(1));
    assign any_o    = |mask_i;

endmodule

// File: rtl/fan_result_collector.sv
// Serializes sparse per-lane FAN results into one result per cycle, buffering whole frames.
module fan_result_collector
    import fan_result_collector_pkg::*;
#(
    parameter int unsigned NUM_PES       = NUM_PES_DEF,
    parameter int unsigned LOG2_PES      = LOG2_PES_DEF,
    parameter int unsigned OUT_DATA_TYPE = OUT_DATA_TYPE_DEF,
    parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int unsigned LOG2_DEPTH    = LOG2_DEPTH_DEF
) (
    input logic                  clk,
    input logic                  rst,
    fan_result_collector_if.slave bus
);

    localparam int unsigned CNT_W = LOG2_DEPTH + 1;

    frame_t                           fifo_mem [FIFO_DEPTH];
    frame_t                           in_frame;
    frame_t                           head;
    logic [LOG2_DEPTH-1:0]            rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [NUM_PES-1:0]               mask_q, mask_d;
    logic [NUM_PES*OUT_DATA_TYPE-1:0] data_q, data_d;
    logic                             overflow_q;

    logic [LOG2_PES-1:0] lsb_idx;
    logic [NUM_PES-1:0]  lsb_onehot;
    logic                lsb_any;
    logic accept, is_last, drain_free, in_valid, fifo_empty, fifo_full;
    logic pop, bypass, push_req, push, drop;

    function automatic logic [LOG2_DEPTH-1:0] ptr_inc(input logic [LOG2_DEPTH-1:0] p);
        return (p == LOG2_DEPTH'(FIFO_DEPTH - 1)) ? '0 : p + LOG2_DEPTH'(1);
    endfunction

    sigma_lsb_encoder #(
        .WIDTH (NUM_PES),
        .IDX_W (LOG2_PES)
    ) u_lsb (
        .mask_i   (mask_q),
        .idx_o    (lsb_idx),
        .onehot_o (lsb_onehot),
        .any_o    (lsb_any)
    );

    always_comb begin
        in_frame.mask = bus.i_data_valid;
        in_frame.data = bus.i_data_bus;
        head          = fifo_mem[rd_ptr_q];

        accept     = lsb_any & bus.i_ready;
        is_last    = lsb_any & (mask_q == lsb_onehot);
        drain_free = ~lsb_any | (accept & is_last);
        in_valid   = |bus.i_data_valid;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

        // FIFO head has priority over the incoming frame to keep strict ordering.
        pop      = drain_free & ~fifo_empty;
        bypass   = drain_free & fifo_empty & in_valid;
        push_req = in_valid & ~bypass;
        push     = push_req & (~fifo_full | pop);
        drop     = push_req & ~push;
    end

    always_comb begin
        mask_d = mask_q;
        data_d = data_q;
        if (accept) mask_d = mask_q & ~lsb_onehot;
        if (pop) begin
            mask_d = head.mask;
            data_d = head.data;
        end else if (bypass) begin
            mask_d = in_frame.mask;
            data_d = in_frame.data;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q     <= '0;
            data_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            data_q     <= data_d;
            count_q    <= count_d;
            overflow_q <= overflow_q | drop;
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= in_frame;
    end

    assign bus.o_valid    = lsb_any;
    assign bus.o_last     = is_last;
    assign bus.o_lane     = lsb_idx;
    assign bus.o_data     = lsb_any ? data_q[lsb_idx*OUT_DATA_TYPE +: OUT_DATA_TYPE] : '0;
    assign bus.o_overflow = overflow_q;
    assign bus.o_count    = count_q;

endmodule

// File: doc/fan_result_collector.md
FAN_RESULT_COLLECTOR -- requirements
Module: fan_result_collector

Interface
REQ-001 SHALL have parameter NUM_PES, default 16, number of result lanes from the FAN network.
REQ-002 SHALL have parameter LOG2_PES, default 4, lane index width.
REQ-003 SHALL have parameter OUT_DATA_TYPE, default 32, result width per lane.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, frame buffer entries; LOG2_DEPTH, default 2.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port i_data_valid, input, NUM_PES, per-lane valid from the flexdpe FAN output.
REQ-008 SHALL have port i_data_bus, input, NUM_PES*OUT_DATA_TYPE, lane k at bits [k*OUT_DATA_TYPE +: OUT_DATA_TYPE].
REQ-009 SHALL have port o_valid, output, 1, serial result valid.
REQ-010 SHALL have port i_ready, input, 1, downstream accept.
REQ-011 SHALL have port o_data, output, OUT_DATA_TYPE, serial result.
REQ-012 SHALL have port o_lane, output, LOG2_PES, source lane of o_data.
REQ-013 SHALL have port o_last, output, 1, high on the final result of a frame.
REQ-014 SHALL have port o_overflow, output, 1, sticky frame-drop flag.
REQ-015 SHALL have port o_count, output, LOG2_DEPTH+1, frames held in the FIFO (excluding drain register).

Function
REQ-016 A "frame" SHALL be one cycle's {i_data_valid, i_data_bus} with i_data_valid != 0; all-zero masks SHALL be ignored.
REQ-017 Drain register SHALL hold {mask, data} of the frame being serialized; o_valid = |mask.
REQ-018 o_data/o_lane SHALL select the lowest-index set bit of mask; o_last = exactly one bit set.
REQ-019 On o_valid && i_ready, that bit SHALL be cleared at the edge; no other state change on !i_ready.
REQ-020 Drain register SHALL reload when empty or when its last result is accepted; source = FIFO head if non-empty, else the incoming frame (bypass), giving zero-bubble back-to-back frames.
REQ-021 Latency: frame sampled at edge N with FIFO and drain idle SHALL give o_valid high after edge N (1 cycle).
REQ-022 Frames not taking the bypass SHALL push to the FIFO; push SHALL be accepted if o_count < FIFO_DEPTH or a pop occurs in the same cycle.
REQ-023 A frame arriving with FIFO full and no same-cycle pop SHALL be dropped whole and o_overflow set until reset.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be strictly first-in first-out.
REQ-025 o_data/o_lane SHALL be don't-care when o_valid low; driven to zero for determinism.

Reset
REQ-026 On rst low, asynchronously: mask=0, FIFO pointers and o_count=0, o_overflow=0, o_valid=0, o_last=0, o_data=0, o_lane=0.
REQ-027 Reset mid-frame SHALL discard all buffered and partially drained frames; no output until a new frame after rst release.
REQ-028 FIFO data storage SHALL NOT require reset.

Structure
REQ-029 NUM_PES, LOG2_PES, OUT_DATA_TYPE defaults and the frame record type {mask, data} SHALL live in the shared SIGMA package.
REQ-030 Lowest-set-bit selection SHALL be one sub-module, sigma_lsb_encoder (mask -> index, one-hot, any).
REQ-031 Frame FIFO SHALL be in-module; no other sub-modules.

Verification
REQ-032 Full frame, mask 0xFFFF, lane k = 0x3F800000+k, i_ready=1 -> 16 consecutive outputs, o_lane 0..15, o_last only on lane 15, first o_valid one cycle after input.
REQ-033 Sparse frame mask 0x8101 -> lanes 0, 8, 15 in 3 cycles, o_last on lane 15; all-zero mask frame -> no output, o_count unchanged.
REQ-034 Back-to-back masks 0x0003 then 0x0001 each cycle with i_ready=1 -> continuous o_valid, no bubble between frames.
REQ-035 i_ready=0, 6 frames of mask 0x0001 -> first in drain, 4 in FIFO (o_count=4), sixth dropped, o_overflow=1; release i_ready -> exactly 5 results in order.
REQ-036 Full FIFO with i_ready=1 and drain finishing same cycle as new frame -> frame accepted, o_overflow stays 0.
REQ-037 rst low while mask 0xFFFF half drained -> o_valid=0 immediately, o_count=0; after release no stale results.
